// File: rtl/mux_prio_enc_pipe_if.sv
// Handshake bundle for mux_prio_enc_pipe: beat in (valid/ready, data, select, mode)
// and encoded result out (valid/ready, word, index, flags).
interface mux_prio_enc_pipe_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
);
    localparam int IDX_W = $clog2(WIDTH);

    logic                      in_valid;
    logic                      in_ready;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]          in_sel;
    logic                      in_mode;
    logic                      out_valid;
    logic                      out_ready;
    logic [WIDTH-1:0]          out_data;
    logic [IDX_W-1:0]          out_idx;
    logic                      out_zero;
    logic                      out_sel_err;

    // Source/consumer side
    modport master (
        output in_valid, in_data, in_sel, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_zero, out_sel_err
    );

    // Block side
    modport slave (
        input  in_valid, in_data, in_sel, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_zero, out_sel_err
    );
endinterface

// File: rtl/mux_prio_enc_pipe.sv
// N-channel word mux feeding a priority encoder, two register stages with
// valid/ready on both ends; per-beat MSB-first or LSB-first encode.
module mux_prio_enc_pipe #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input logic                 clk,
    input logic                 rst_n,
    mux_prio_enc_pipe_if.slave  bus
);
    localparam int IDX_W = $clog2(WIDTH);

    logic             r_s1_v;
    logic [WIDTH-1:0] r_s1_word;
    logic             r_s1_mode;
    logic             r_s1_err;

    logic             r_s2_v;
    logic [WIDTH-1:0] r_out_data;
    logic [IDX_W-1:0] r_out_idx;
    logic             r_out_zero;
    logic             r_out_err;

    logic             w_sel_err;
    logic [WIDTH-1:0] w_word;
    logic             w_in_fire;
    logic             w_s2_load;

    // Mode 0 keeps the last (highest) set bit seen going up; mode 1 the last going down.
    function automatic logic [IDX_W-1:0] f_encode(input logic [WIDTH-1:0] w, input logic m);
        logic [IDX_W-1:0] idx;
        idx = '0;
        if (!m) begin
            for (int i = 0; i < WIDTH; i++)
                if (w[i]) idx = IDX_W'(i);
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--)
                if (w[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    assign w_sel_err = ({1'b0, bus.in_sel} >= (SEL_W + 1)'(CHANNELS));

    always_comb begin
        w_word = '0;
        for (int c = 0; c < CHANNELS; c++)
            if (bus.in_sel == SEL_W'(c)) w_word = bus.in_data[c*WIDTH +: WIDTH];
        if (w_sel_err) w_word = '0;
    end

    assign w_s2_load    = r_s1_v & (~r_s2_v | bus.out_ready);
    assign bus.in_ready = rst_n & (~r_s1_v | ~r_s2_v | bus.out_ready);
    assign w_in_fire    = bus.in_valid & bus.in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_v     <= 1'b0;
            r_s1_word  <= '0;
            r_s1_mode  <= 1'b0;
            r_s1_err   <= 1'b0;
            r_s2_v     <= 1'b0;
            r_out_data <= '0;
            r_out_idx  <= '0;
            r_out_zero <= 1'b0;
            r_out_err  <= 1'b0;
        end else begin
            // S1 holds when it cannot hand off and nothing new arrives
            if (w_in_fire) begin
                r_s1_v    <= 1'b1;
                r_s1_word <= w_word;
                r_s1_mode <= bus.in_mode;
                r_s1_err  <= w_sel_err;
            end else if (w_s2_load) begin
                r_s1_v <= 1'b0;
            end

            if (w_s2_load) begin
                r_s2_v     <= 1'b1;
                r_out_data <= r_s1_word;
                r_out_idx  <= f_encode(r_s1_word, r_s1_mode);
                r_out_zero <= (r_s1_word == '0);
                r_out_err  <= r_s1_err;
            end else if (bus.out_ready) begin
                r_s2_v <= 1'b0;
            end
        end
    end

    assign bus.out_valid   = r_s2_v;
    assign bus.out_data    = r_out_data;
    assign bus.out_idx     = r_out_idx;
    assign bus.out_zero    = r_out_zero;
    assign bus.out_sel_err = r_out_err;
endmodule

// File: tb/tb_mux_prio_enc_pipe.sv
// Directed bench: a table of streamed beats on a 4-channel build, then hand-written
// backpressure, mid-operation reset and out-of-range select (3-channel build) sequences.
module tb_mux_prio_enc_pipe;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;

    mux_prio_enc_pipe_if #(.WIDTH(8), .CHANNELS(4)) bus4 ();
    mux_prio_enc_pipe_if #(.WIDTH(8), .CHANNELS(3)) bus3 ();

    mux_prio_enc_pipe #(.WIDTH(8), .CHANNELS(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    mux_prio_enc_pipe #(.WIDTH(8), .CHANNELS(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  sel;
        logic        mode;
        logic [7:0]  e_data;
        logic [2:0]  e_idx;
        logic        e_zero;
    } vec_t;

    localparam logic [31:0] D0 = {8'd7, 8'd56, 8'd23, 8'd156};
    localparam logic [31:0] DZ = {8'd7, 8'd0,  8'd23, 8'd156};
    localparam logic [31:0] DB = {8'h01, 8'h80, 8'hFF, 8'h00};

    vec_t vec[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [13:0] pk4();
        return {bus4.out_valid, bus4.out_data, bus4.out_idx, bus4.out_zero, bus4.out_sel_err};
    endfunction

    function automatic logic [13:0] pk3();
        return {bus3.out_valid, bus3.out_data, bus3.out_idx, bus3.out_zero, bus3.out_sel_err};
    endfunction

    task automatic drive4(input logic [31:0] d, input logic [1:0] s, input logic m);
        bus4.in_valid = 1'b1;
        bus4.in_data  = d;
        bus4.in_sel   = s;
        bus4.in_mode  = m;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        vec[0]  = '{D0, 2'd0, 1'b0, 8'd156, 3'd7, 1'b0};
        vec[1]  = '{D0, 2'd1, 1'b0, 8'd23,  3'd4, 1'b0};
        vec[2]  = '{D0, 2'd2, 1'b0, 8'd56,  3'd5, 1'b0};
        vec[3]  = '{D0, 2'd3, 1'b0, 8'd7,   3'd2, 1'b0};
        vec[4]  = '{D0, 2'd0, 1'b1, 8'd156, 3'd2, 1'b0};
        vec[5]  = '{D0, 2'd1, 1'b1, 8'd23,  3'd0, 1'b0};
        vec[6]  = '{D0, 2'd2, 1'b1, 8'd56,  3'd3, 1'b0};
        vec[7]  = '{D0, 2'd3, 1'b1, 8'd7,   3'd0, 1'b0};
        vec[8]  = '{DZ, 2'd2, 1'b0, 8'd0,   3'd0, 1'b1};
        vec[9]  = '{DZ, 2'd2, 1'b1, 8'd0,   3'd0, 1'b1};
        vec[10] = '{DB, 2'd1, 1'b1, 8'hFF,  3'd0, 1'b0};
        vec[11] = '{DB, 2'd2, 1'b1, 8'h80,  3'd7, 1'b0};
        vec[12] = '{DB, 2'd3, 1'b0, 8'h01,  3'd0, 1'b0};

        rst_n = 1'b0;
        bus4.in_valid = 1'b0; bus4.in_data = '0; bus4.in_sel = '0; bus4.in_mode = 1'b0; bus4.out_ready = 1'b1;
        bus3.in_valid = 1'b0; bus3.in_data = '0; bus3.in_sel = '0; bus3.in_mode = 1'b0; bus3.out_ready = 1'b1;
        tick();
        tick();
        chk("reset_out4", 32'(pk4()), 32'd0);
        chk("reset_out3", 32'(pk3()), 32'd0);
        chk("reset_in_ready4", 32'(bus4.in_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("post_reset_in_ready4", 32'(bus4.in_ready), 32'd1);

        // Back-to-back stream: beat t shows up right after edge t+1
        for (int t = 0; t <= 13; t++) begin
            if (t < 13) begin
                drive4(vec[t].data, vec[t].sel, vec[t].mode);
                #1;
                chk($sformatf("stream_in_ready%0d", t), 32'(bus4.in_ready), 32'd1);
            end else begin
                bus4.in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            if (t == 0)
                chk("stream_no_early_valid", 32'(bus4.out_valid), 32'd0);
            else
                chk($sformatf("stream_vec%0d", t - 1), 32'(pk4()),
                    32'({1'b1, vec[t-1].e_data, vec[t-1].e_idx, vec[t-1].e_zero, 1'b0}));
        end
        tick();
        chk("stream_drained", 32'(bus4.out_valid), 32'd0);

        // Backpressure: two beats fill the pipe, third is refused until out_ready rises
        bus4.out_ready = 1'b0;
        drive4(D0, 2'd0, 1'b0);
        #1; chk("bp_acc_a", 32'(bus4.in_ready), 32'd1);
        tick();
        chk("bp_a_not_out_yet", 32'(bus4.out_valid), 32'd0);
        drive4(D0, 2'd1, 1'b0);
        #1; chk("bp_acc_b", 32'(bus4.in_ready), 32'd1);
        tick();
        chk("bp_a_out", 32'(pk4()), 32'({1'b1, 8'd156, 3'd7, 1'b0, 1'b0}));
        drive4(D0, 2'd2, 1'b0);
        #1; chk("bp_full_refuse", 32'(bus4.in_ready), 32'd0);
        tick();
        chk("bp_a_stable", 32'(pk4()), 32'({1'b1, 8'd156, 3'd7, 1'b0, 1'b0}));
        chk("bp_still_refuse", 32'(bus4.in_ready), 32'd0);
        bus4.out_ready = 1'b1;
        #1; chk("bp_release_ready", 32'(bus4.in_ready), 32'd1);
        tick();
        bus4.in_valid = 1'b0;
        chk("bp_b_out", 32'(pk4()), 32'({1'b1, 8'd23, 3'd4, 1'b0, 1'b0}));
        tick();
        chk("bp_c_out", 32'(pk4()), 32'({1'b1, 8'd56, 3'd5, 1'b0, 1'b0}));
        tick();
        chk("bp_empty", 32'(bus4.out_valid), 32'd0);

        // Reset with both stages full: nothing survives
        bus4.out_ready = 1'b0;
        drive4(D0, 2'd3, 1'b0);
        tick();
        drive4(D0, 2'd0, 1'b1);
        tick();
        chk("rst_pre_full", 32'(pk4()), 32'({1'b1, 8'd7, 3'd2, 1'b0, 1'b0}));
        rst_n = 1'b0;
        drive4(D0, 2'd1, 1'b0);
        #1; chk("rst_in_ready_low", 32'(bus4.in_ready), 32'd0);
        tick();
        chk("rst_mid_out", 32'(pk4()), 32'd0);
        rst_n = 1'b1;
        bus4.in_valid = 1'b0;
        bus4.out_ready = 1'b1;
        #1; chk("rst_in_ready_after", 32'(bus4.in_ready), 32'd1);
        tick();
        chk("rst_no_stale1", 32'(bus4.out_valid), 32'd0);
        drive4(D0, 2'd2, 1'b1);
        tick();
        bus4.in_valid = 1'b0;
        chk("rst_no_stale2", 32'(bus4.out_valid), 32'd0);
        tick();
        chk("rst_new_beat", 32'(pk4()), 32'({1'b1, 8'd56, 3'd3, 1'b0, 1'b0}));
        tick();
        chk("rst_only_one", 32'(bus4.out_valid), 32'd0);

        // 3-channel build: select 3 is out of range
        bus3.in_valid = 1'b1;
        bus3.in_data  = {8'd56, 8'd23, 8'd156};
        bus3.in_sel   = 2'd3;
        bus3.in_mode  = 1'b0;
        #1; chk("ch3_in_ready", 32'(bus3.in_ready), 32'd1);
        tick();
        bus3.in_sel  = 2'd2;
        bus3.in_mode = 1'b1;
        tick();
        chk("ch3_sel_err", 32'(pk3()), 32'({1'b1, 8'd0, 3'd0, 1'b1, 1'b1}));
        bus3.in_sel  = 2'd3;
        bus3.in_mode = 1'b1;
        tick();
        bus3.in_valid = 1'b0;
        chk("ch3_sel2_ok", 32'(pk3()), 32'({1'b1, 8'd56, 3'd3, 1'b0, 1'b0}));
        tick();
        chk("ch3_sel_err_mode1", 32'(pk3()), 32'({1'b1, 8'd0, 3'd0, 1'b1, 1'b1}));
        tick();
        chk("ch3_empty", 32'(bus3.out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
